// File: rtl/kb_cmd_sched.sv
// kb_cmd_sched -- keyboard command scheduler.
//
// Pops ASCII codes from the PS/2 keyboard buffer one at a time. Each code is
// decoded into a command for one of two players. Each player has a one-entry
// command slot with a valid/ack handshake toward game logic. After an ack,
// that player's valid output is held low for a cooldown period.
//
// Ports:
//   clk, reset           system clock; asynchronous active-low reset
//   kb_not_empty         keyboard buffer holds a code (ascii_code is valid)
//   ascii_code[7:0]      head-of-buffer ASCII code
//   rd_key               one-cycle pop strobe to the keyboard buffer
//   p1_cmd/p1_valid/p1_ack  player 1 command slot handshake
//   p2_cmd/p2_valid/p2_ack  player 2 command slot handshake
//   drop_cnt[7:0]        saturating count of overwritten/discarded commands
//   paused               pause state
//
// Command encoding: 0 none, 1 up, 2 down, 3 left, 4 right, 5 bomb.
//
// Optional feature, macro KB_CMD_PAUSE_EN:
//   When the macro is defined, key 'p' (0x70) toggles `paused`. While paused,
//   both valid outputs are forced low and the cooldown timers freeze. Keys
//   still pop and slots still update while paused.
//   When the macro is undefined, 0x70 is an ordinary unmapped key and
//   `paused` is tied to 0.
module kb_cmd_sched #(
    parameter int COOLDOWN = 16,
    parameter int CW       = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       kb_not_empty,
    input  logic [7:0] ascii_code,
    output logic       rd_key,
    output logic [2:0] p1_cmd,
    output logic       p1_valid,
    input  logic       p1_ack,
    output logic [2:0] p2_cmd,
    output logic       p2_valid,
    input  logic       p2_ack,
    output logic [7:0] drop_cnt,
    output logic       paused
);

    localparam int             NUM_PL  = 2;
    localparam logic [CW-1:0]  CD_LOAD = CW'(COOLDOWN);

    localparam logic [2:0] CMD_NONE  = 3'd0;
    localparam logic [2:0] CMD_UP    = 3'd1;
    localparam logic [2:0] CMD_DOWN  = 3'd2;
    localparam logic [2:0] CMD_LEFT  = 3'd3;
    localparam logic [2:0] CMD_RIGHT = 3'd4;
    localparam logic [2:0] CMD_BOMB  = 3'd5;

    typedef enum logic [1:0] {IDLE, POP, SETTLE} state_e;

    state_e state_q, state_d;
    logic [7:0] key_q, key_d;
    logic [7:0] drop_cnt_q, drop_cnt_d;
    logic       paused_q, paused_d;

    logic [NUM_PL-1:0][2:0] dec_cmd;
    logic [NUM_PL-1:0]      dec_hit;
    logic [NUM_PL-1:0][2:0] pl_cmd;
    logic [NUM_PL-1:0]      pl_valid;
    logic [NUM_PL-1:0]      pl_drop;
    logic [NUM_PL-1:0]      pl_ack;

    assign pl_ack = {p2_ack, p1_ack};

    // ---------------------------------------------------------------- FSM
    // The key is latched on leaving IDLE. The POP cycle therefore decodes a
    // stable value even if the buffer empties underneath it. SETTLE gives the
    // buffer one cycle to update its empty flag after the pop.
    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        rd_key  = 1'b0;
        case (state_q)
            IDLE: begin
                if (kb_not_empty) begin
                    key_d   = ascii_code;
                    state_d = POP;
                end
            end
            POP: begin
                rd_key  = 1'b1;
                state_d = SETTLE;
            end
            SETTLE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            key_q   <= 8'h00;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
        end
    end

    // ------------------------------------------------------------- decode
    always_comb begin
        dec_hit = '0;
        dec_cmd = '0;
        case (key_q)
            8'h77: begin dec_hit[0] = 1'b1; dec_cmd[0] = CMD_UP;    end
            8'h73: begin dec_hit[0] = 1'b1; dec_cmd[0] = CMD_DOWN;  end
            8'h61: begin dec_hit[0] = 1'b1; dec_cmd[0] = CMD_LEFT;  end
            8'h64: begin dec_hit[0] = 1'b1; dec_cmd[0] = CMD_RIGHT; end
            8'h20: begin dec_hit[0] = 1'b1; dec_cmd[0] = CMD_BOMB;  end
            8'h69: begin dec_hit[1] = 1'b1; dec_cmd[1] = CMD_UP;    end
            8'h6B: begin dec_hit[1] = 1'b1; dec_cmd[1] = CMD_DOWN;  end
            8'h6A: begin dec_hit[1] = 1'b1; dec_cmd[1] = CMD_LEFT;  end
            8'h6C: begin dec_hit[1] = 1'b1; dec_cmd[1] = CMD_RIGHT; end
            8'h6D: begin dec_hit[1] = 1'b1; dec_cmd[1] = CMD_BOMB;  end
            default: ;
        endcase
    end

    // -------------------------------------------------------------- pause
`ifdef KB_CMD_PAUSE_EN
    always_comb begin
        paused_d = paused_q ^ (rd_key && (key_q == 8'h70));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) paused_q <= 1'b0;
        else        paused_q <= paused_d;
    end
`else
    assign paused_d = 1'b0;
    assign paused_q = 1'b0;
`endif

    // ---------------------------------------------------------- per player
    for (genvar g = 0; g < NUM_PL; g++) begin : g_pl
        logic [2:0]    cmd_q, cmd_d, cur;
        logic [CW-1:0] cd_q, cd_d;
        logic          valid_q, valid_d;
        logic          ack_ok, load, drop;

        always_comb begin
            ack_ok = pl_ack[g] & valid_q;
            load   = rd_key & dec_hit[g];
            // An ack in the same cycle as a load frees the slot first.
            // The incoming key then lands in an empty slot and is not a drop.
            cur    = ack_ok ? CMD_NONE : cmd_q;
            cmd_d  = cur;
            drop   = 1'b0;
            if (load) begin
                if (cur == CMD_NONE) begin
                    cmd_d = dec_cmd[g];
                end else begin
                    drop = 1'b1;
                    // A pending bomb is never displaced. A pending move is
                    // replaced by any newer command.
                    if (cur != CMD_BOMB) cmd_d = dec_cmd[g];
                end
            end

            if (ack_ok)                          cd_d = CD_LOAD;
            else if (cd_q != '0 && !paused_d)    cd_d = cd_q - CW'(1);
            else                                 cd_d = cd_q;

            // valid is computed from next-state values so that it is
            // registered in the same cycle as the slot and timer it reflects.
            valid_d = (cmd_d != CMD_NONE) && (cd_d == '0) && !paused_d;
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                cmd_q   <= CMD_NONE;
                cd_q    <= '0;
                valid_q <= 1'b0;
            end else begin
                cmd_q   <= cmd_d;
                cd_q    <= cd_d;
                valid_q <= valid_d;
            end
        end

        assign pl_cmd[g]   = cmd_q;
        assign pl_valid[g] = valid_q;
        assign pl_drop[g]  = drop;
    end

    // ----------------------------------------------------------- drop count
    // A single key maps to at most one player, so at most one drop per pop.
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if ((|pl_drop) && (drop_cnt_q != 8'hFF)) drop_cnt_d = drop_cnt_q + 8'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) drop_cnt_q <= 8'h00;
        else        drop_cnt_q <= drop_cnt_d;
    end

    assign p1_cmd   = pl_cmd[0];
    assign p1_valid = pl_valid[0];
    assign p2_cmd   = pl_cmd[1];
    assign p2_valid = pl_valid[1];
    assign drop_cnt = drop_cnt_q;
    assign paused   = paused_q;

endmodule

// File: tb/tb_kb_cmd_sched.sv
// Directed testbench for kb_cmd_sched.
// The default build uses COOLDOWN=16. The pause checks are compiled in only
// when KB_CMD_PAUSE_EN is defined.
module tb_kb_cmd_sched;

    logic       clk = 1'b0;
    logic       reset;
    logic       kb_not_empty;
    logic [7:0] ascii_code;
    logic       rd_key;
    logic [2:0] p1_cmd, p2_cmd;
    logic       p1_valid, p2_valid, p1_ack, p2_ack;
    logic [7:0] drop_cnt;
    logic       paused;

    kb_cmd_sched #(.COOLDOWN(16), .CW(16)) dut (
        .clk(clk), .reset(reset),
        .kb_not_empty(kb_not_empty), .ascii_code(ascii_code), .rd_key(rd_key),
        .p1_cmd(p1_cmd), .p1_valid(p1_valid), .p1_ack(p1_ack),
        .p2_cmd(p2_cmd), .p2_valid(p2_valid), .p2_ack(p2_ack),
        .drop_cnt(drop_cnt), .paused(paused)
    );

    always #5 clk = ~clk;

    int   nvec = 0, nerr = 0;
    int   cyc = 0, rd_cnt = 0, rd_consec = 0;
    logic rd_prev = 1'b0;
    int   last_rd = 0;
    int   exp_drop = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rd_key) rd_cnt <= rd_cnt + 1;
        if (rd_key && rd_prev) rd_consec <= rd_consec + 1;
        rd_prev <= rd_key;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        nvec++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present one code and wait for its pop. Returns one cycle after the POP
    // cycle, when the slot update is visible. When a2 is set, p2_ack is
    // driven during the POP cycle itself.
    task automatic send_key(input logic [7:0] k, input logic a2);
        int n = 0;
        kb_not_empty = 1'b1;
        ascii_code   = k;
        while (!rd_key && n < 20) begin
            tick(1);
            n++;
        end
        if (!rd_key) begin
            chk("rd_timeout", int'(rd_key), 1);
            kb_not_empty = 1'b0;
            return;
        end
        last_rd      = cyc;
        kb_not_empty = 1'b0;
        p2_ack       = a2;
        tick(1);
        p2_ack       = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        int c0, r1, ca, n, rc;
        logic [7:0] unm [$];

        reset = 1'b0; kb_not_empty = 1'b0; ascii_code = 8'h00;
        p1_ack = 1'b0; p2_ack = 1'b0;
        tick(2);
        chk("rst_rd", int'(rd_key), 0);
        chk("rst_p1c", int'(p1_cmd), 0);
        chk("rst_p1v", int'(p1_valid), 0);
        chk("rst_p2c", int'(p2_cmd), 0);
        chk("rst_p2v", int'(p2_valid), 0);
        chk("rst_drop", int'(drop_cnt), 0);
        chk("rst_pause", int'(paused), 0);
        reset = 1'b1;
        tick(1);

        // Two keys back to back: rd_key pulses at t+1 and t+4.
        c0 = cyc;
        send_key(8'h77, 1'b0);
        chk("rd_lat", last_rd - c0, 1);
        r1 = last_rd;
        send_key(8'h6C, 1'b0);
        chk("rd_gap", last_rd - r1, 3);
        chk("p1_up", int'(p1_cmd), 1);
        chk("p1_up_v", int'(p1_valid), 1);
        chk("p2_rt", int'(p2_cmd), 4);
        chk("p2_rt_v", int'(p2_valid), 1);
        chk("drop0", int'(drop_cnt), 0);

        // Overwrite rules on P1: move over move, bomb over move, move vs bomb.
        send_key(8'h64, 1'b0);
        chk("ow_right", int'(p1_cmd), 4);
        chk("ow_drop1", int'(drop_cnt), 1);
        send_key(8'h20, 1'b0);
        chk("ow_bomb", int'(p1_cmd), 5);
        chk("ow_drop2", int'(drop_cnt), 2);
        send_key(8'h61, 1'b0);
        chk("bomb_keep", int'(p1_cmd), 5);
        chk("ow_drop3", int'(drop_cnt), 3);
        chk("bomb_v", int'(p1_valid), 1);
        exp_drop = 3;

        // P2 ack drains its slot.
        p2_ack = 1'b1; tick(1); p2_ack = 1'b0;
        chk("p2_ack_c", int'(p2_cmd), 0);
        chk("p2_ack_v", int'(p2_valid), 0);

        // Cooldown on P1. ca is the first cycle after the ack edge, i.e. t+1.
        p1_ack = 1'b1; tick(1); p1_ack = 1'b0;
        ca = cyc;
        chk("p1_ack_c", int'(p1_cmd), 0);
        chk("p1_ack_v", int'(p1_valid), 0);
        send_key(8'h73, 1'b0);
        chk("cd_load_c", int'(p1_cmd), 2);
        chk("cd_load_v", int'(p1_valid), 0);
        chk("cd_drop", int'(drop_cnt), exp_drop);
        // This ack arrives while valid is low, so it must be ignored.
        p1_ack = 1'b1; tick(1); p1_ack = 1'b0;
        n = 0;
        while (!p1_valid && n < 40) begin tick(1); n++; end
        chk("cd_rise", cyc - ca, 16);
        chk("cd_keep_c", int'(p1_cmd), 2);

        // P2: ack and a new key land in the same POP cycle.
        send_key(8'h69, 1'b0);
        chk("p2_up", int'(p2_cmd), 1);
        chk("p2_up_v", int'(p2_valid), 1);
        send_key(8'h6B, 1'b1);
        chk("sim_c", int'(p2_cmd), 2);
        chk("sim_v", int'(p2_valid), 0);
        chk("sim_drop", int'(drop_cnt), exp_drop);
        tick(20);
        chk("sim_v_late", int'(p2_valid), 1);

        // Unmapped codes pop once each and leave the slots untouched.
        unm.push_back(8'h41);
        unm.push_back(8'h00);
`ifndef KB_CMD_PAUSE_EN
        unm.push_back(8'h70);
`endif
        foreach (unm[i]) begin
            rc = rd_cnt;
            send_key(unm[i], 1'b0);
            chk("unm_pop", rd_cnt - rc, 1);
            chk("unm_p1", int'(p1_cmd), 2);
            chk("unm_p2", int'(p2_cmd), 2);
            chk("unm_drop", int'(drop_cnt), exp_drop);
        end
        chk("unm_pause", int'(paused), 0);

`ifdef KB_CMD_PAUSE_EN
        send_key(8'h70, 1'b0);
        chk("pz_on", int'(paused), 1);
        chk("pz_p1v", int'(p1_valid), 0);
        chk("pz_p2v", int'(p2_valid), 0);
        send_key(8'h77, 1'b0);
        exp_drop++;
        chk("pz_p1c", int'(p1_cmd), 1);
        chk("pz_p1v2", int'(p1_valid), 0);
        chk("pz_drop", int'(drop_cnt), exp_drop);
        send_key(8'h70, 1'b0);
        chk("pz_off", int'(paused), 0);
        chk("pz_p1v3", int'(p1_valid), 1);
`endif

        // Saturation: 300 further P1 overwrites.
        for (int i = 0; i < 300; i++) send_key((i % 2) ? 8'h61 : 8'h64, 1'b0);
        chk("sat_drop", int'(drop_cnt), 255);
        chk("sat_p1c", int'(p1_cmd), 3);
        chk("rd_consec", rd_consec, 0);

        // Asynchronous reset while in POP.
        kb_not_empty = 1'b1;
        ascii_code   = 8'h69;
        n = 0;
        while (!rd_key && n < 20) begin tick(1); n++; end
        chk("pre_rst_rd", int'(rd_key), 1);
        #2 reset = 1'b0;
        #1;
        chk("arst_rd", int'(rd_key), 0);
        chk("arst_p1c", int'(p1_cmd), 0);
        chk("arst_p1v", int'(p1_valid), 0);
        chk("arst_p2c", int'(p2_cmd), 0);
        chk("arst_p2v", int'(p2_valid), 0);
        chk("arst_drop", int'(drop_cnt), 0);
        chk("arst_pause", int'(paused), 0);
        kb_not_empty = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        rc = rd_cnt;
        tick(6);
        chk("post_rst_rd", rd_cnt - rc, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
